pattern_bit_serializer: RTL

- Upstream feeder for the serial pattern-recognizer FSMs.
- Accepts parallel words through a valid/ready handshake and shifts them out one bit per clock on string_out, which wires directly to the recognizer's string_in.
- Has a one-entry holding register so back-to-back words stream with no bubble.
- Inserts optional idle gaps between words, driving a fixed idle level.

---
 rtl/pattern_bit_serializer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pattern_bit_serializer.sv
// pattern_bit_serializer
//   Takes parallel words over a valid/ready handshake and shifts them out one
//   bit per clock on string_out, which feeds a serial pattern recognizer. A
//   one-entry hold register lets back-to-back words stream without a bubble,
//   and an optional idle gap can be inserted after every word.
//
// Ports
//   clk          system clock, all state changes on posedge
//   reset        synchronous, active-high
//   data_in      parallel word (WIDTH bits)
//   data_valid   producer has a word on data_in
//   data_ready   hold register is empty, a word can be accepted (registered)
//   string_out   serial bit stream, IDLE_BIT when no data bit (registered)
//   bit_valid    string_out carries a data bit (registered)
//   frame_start  one-cycle pulse with the first bit of each word (registered)
//   busy         not IDLE, or a word is held (registered)
//
// state   | meaning
// S_IDLE  | nothing being shifted; loads the held word when one arrives
// S_SHIFT | presenting data bits, bit_cnt = index of the bit on string_out
// S_GAP   | driving IDLE_BIT for GAP cycles after a word

module pattern_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             string_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  // Unused when GAP = 0; kept at zero so the constant stays in range.
  localparam logic [7:0] LAST_GAP = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold_reg, hold_n;
  logic             hold_full, hold_full_n;
  logic [WIDTH-1:0] shifter, shifter_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [7:0]       gap_cnt, gap_cnt_n;
  logic             string_n, bit_valid_n, frame_n, busy_n, ready_n;
  logic             accept, load;

  // Bit that goes out next from a word, and the word with that bit removed.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_n     = state;
    hold_n      = hold_reg;
    hold_full_n = hold_full;
    shifter_n   = shifter;
    bit_cnt_n   = bit_cnt;
    gap_cnt_n   = gap_cnt;
    string_n    = IDLE_BIT;
    bit_valid_n = 1'b0;
    frame_n     = 1'b0;
    load        = 1'b0;
    accept      = data_valid && data_ready;

    case (state)
      S_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      S_SHIFT: begin
        if (bit_cnt != LAST_BIT) begin
          string_n    = head_bit(shifter);
          shifter_n   = drop_head(shifter);
          bit_cnt_n   = bit_cnt + CNT_W'(1);
          bit_valid_n = 1'b1;
        end else if (GAP > 0) begin
          state_n   = S_GAP;
          gap_cnt_n = 8'd0;
        end else if (hold_full) begin
          load = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == LAST_GAP) begin
          if (hold_full) load = 1'b1;
          else           state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // The first bit is presented on the load edge itself, so the shifter
    // keeps only the remaining WIDTH-1 bits.
    if (load) begin
      state_n     = S_SHIFT;
      string_n    = head_bit(hold_reg);
      shifter_n   = drop_head(hold_reg);
      bit_cnt_n   = '0;
      bit_valid_n = 1'b1;
      frame_n     = 1'b1;
      hold_full_n = 1'b0;
    end

    // data_ready is low whenever hold_full is set, so accept and load never
    // coincide.
    if (accept) begin
      hold_n      = data_in;
      hold_full_n = 1'b1;
    end

    busy_n  = (state_n != S_IDLE) || hold_full_n;
    ready_n = !hold_full_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      shifter     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= 8'd0;
      string_out  <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      data_ready  <= 1'b1;
    end else begin
      state       <= state_n;
      hold_reg    <= hold_n;
      hold_full   <= hold_full_n;
      shifter     <= shifter_n;
      bit_cnt     <= bit_cnt_n;
      gap_cnt     <= gap_cnt_n;
      string_out  <= string_n;
      bit_valid   <= bit_valid_n;
      frame_start <= frame_n;
      busy        <= busy_n;
      data_ready  <= ready_n;
    end
  end

endmodule
